// File: rtl/sudoku_grid_tx.sv
// Streams the marked cells of a captured 9x9 sudoku grid as indexed beats in
// ascending cell order over a valid/ready channel, with abort and statistics.
module sudoku_grid_tx #(
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [323:0] load_grid,
  input  logic [80:0]  load_mask,
  input  logic         abort,
  output logic         cell_valid,
  input  logic         cell_ready,
  output logic [6:0]   cell_index,
  output logic [3:0]   cell_value,
  output logic         cell_first,
  output logic         cell_last,
  output logic         empty_done,
  output logic         bad_digit,
  output logic [15:0]  grids_sent,
  output logic [31:0]  cells_sent
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state;
  logic [323:0]   grid_q;
  logic [80:0]    rem_q;
  logic           first_q;

  logic [80:0]    elig;
  logic [80:0]    low_bit;
  logic [6:0]     low_idx;
  logic           rem_single;
  logic           beat_fire;
  logic           load_fire;

  always_comb begin
    for (int i = 0; i < 81; i++) begin
      elig[i] = load_mask[i] && (!SKIP_EMPTY || (load_grid[4*i +: 4] != 4'd0));
    end
  end

  // Isolate the lowest set bit; clearing it on each beat yields ascending order.
  assign low_bit    = rem_q & (~rem_q + 81'd1);
  assign rem_single = (rem_q != '0) && ((rem_q & (rem_q - 81'd1)) == '0);

  // NOTE: give every always_comb output a default before any conditional
  // assignment, otherwise the unassigned paths infer a latch.
  always_comb begin
    low_idx = '0;
    for (int i = 80; i >= 0; i--) begin
      if (rem_q[i]) low_idx = 7'(i);
    end
  end

  // Outputs decode only registered state, so ready/valid never reach them combinationally.
  assign load_ready = (state == IDLE);
  assign cell_valid = (state == SEND);
  assign cell_index = low_idx;
  assign cell_value = cell_valid ? grid_q[{low_idx, 2'b00} +: 4] : 4'd0;
  assign cell_first = cell_valid && first_q;
  assign cell_last  = cell_valid && rem_single;

  assign beat_fire = cell_valid && cell_ready;
  assign load_fire = load_valid && load_ready && !abort;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      // NOTE: the grid store is reset too, so cell_value is defined to be 0
      // from reset rather than depending on power-up contents.
      grid_q     <= '0;
      rem_q      <= '0;
      first_q    <= 1'b0;
      empty_done <= 1'b0;
      bad_digit  <= 1'b0;
      grids_sent <= '0;
      cells_sent <= '0;
    end else begin
      empty_done <= 1'b0;

      if (beat_fire) begin
        cells_sent <= cells_sent + 32'd1;
        if (cell_value >= 4'd10) bad_digit <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (load_fire) begin
            grid_q  <= load_grid;
            rem_q   <= elig;
            first_q <= 1'b1;
            if (elig == '0) begin
              empty_done <= 1'b1;
              grids_sent <= grids_sent + 16'd1;
            end else begin
              state <= SEND;
            end
          end
        end
        SEND: begin
          // Abort wins over a coincident beat: the beat counts, the grid does not.
          if (abort) begin
            state   <= IDLE;
            rem_q   <= '0;
            first_q <= 1'b0;
          end else if (beat_fire) begin
            rem_q   <= rem_q & ~low_bit;
            first_q <= 1'b0;
            if (rem_single) begin
              state      <= IDLE;
              grids_sent <= grids_sent + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_grid_tx.sv
// Directed bench for sudoku_grid_tx: table of grid/mask vectors checked against
// a reference cell list, plus hand sequences for stall, abort, reset and bad digits.
module tb_sudoku_grid_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [323:0] load_grid;
  logic [80:0]  load_mask;
  logic         abort;
  logic         cell_valid;
  logic         cell_ready;
  logic [6:0]   cell_index;
  logic [3:0]   cell_value;
  logic         cell_first;
  logic         cell_last;
  logic         empty_done;
  logic         bad_digit;
  logic [15:0]  grids_sent;
  logic [31:0]  cells_sent;

  sudoku_grid_tx dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_grid  (load_grid),
    .load_mask  (load_mask),
    .abort      (abort),
    .cell_valid (cell_valid),
    .cell_ready (cell_ready),
    .cell_index (cell_index),
    .cell_value (cell_value),
    .cell_first (cell_first),
    .cell_last  (cell_last),
    .empty_done (empty_done),
    .bad_digit  (bad_digit),
    .grids_sent (grids_sent),
    .cells_sent (cells_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] idx;
    logic [3:0] val;
    logic       first;
    logic       last;
  } beat_t;

  typedef struct {
    string        name;
    logic [323:0] grid;
    logic [80:0]  mask;
    int           exp_beats;
    int           exp_fidx;
    int           exp_fval;
    int           exp_lidx;
    int           exp_lval;
  } vec_t;

  int    n_checks = 0;
  int    n_errors = 0;
  int    exp_grids = 0;
  int    exp_cells = 0;
  beat_t got_q[$];
  beat_t exp_q[$];

  logic [323:0] full_grid, sparse_grid, zero_grid, bad_grid;
  logic [80:0]  all_ones;
  vec_t         vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: every marked, non-zero cell in ascending index order.
  task automatic build_model(input logic [323:0] grid, input logic [80:0] mask);
    beat_t b;
    int    n;
    exp_q.delete();
    n = 0;
    for (int i = 0; i < 81; i++) if (mask[i] && grid[4*i +: 4] != 4'd0) n++;
    for (int i = 0; i < 81; i++) begin
      if (mask[i] && grid[4*i +: 4] != 4'd0) begin
        b.idx   = 7'(i);
        b.val   = grid[4*i +: 4];
        b.first = (exp_q.size() == 0);
        b.last  = (exp_q.size() == n - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge after the grid finished.
  task automatic run_grid(input string name, input logic [323:0] grid, input logic [80:0] mask,
                          input bit random_ready);
    beat_t snap, held;
    bit    stalled;
    bit    r;
    int    cycles;
    build_model(grid, mask);
    check({name, " load_ready"}, 64'(load_ready), 64'd1);
    load_grid  = grid;
    load_mask  = mask;
    load_valid = 1'b1;
    cell_ready = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    check({name, " empty_done"}, 64'(empty_done), 64'(exp_q.size() == 0));
    got_q.delete();
    stalled = 1'b0;
    held    = '0;
    cycles  = 0;
    while (cell_valid && cycles < 400) begin
      snap = '{cell_index, cell_value, cell_first, cell_last};
      if (stalled) check({name, " stall hold"}, 64'(snap), 64'(held));
      r = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cell_ready = r;
      if (r) got_q.push_back(snap);
      stalled = !r;
      held    = snap;
      @(negedge clk);
      cycles++;
    end
    cell_ready = 1'b0;
    check({name, " timeout"}, 64'(cycles < 400), 64'd1);
    check({name, " idle after"}, 64'({cell_valid, load_ready}), 64'b01);
    check({name, " beat count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      check($sformatf("%s beat %0d", name, k), 64'(got_q[k]), 64'(exp_q[k]));
    if (!random_ready && exp_q.size() > 0)
      check({name, " back-to-back"}, 64'(cycles), 64'(exp_q.size()));
    exp_grids++;
    exp_cells += exp_q.size();
    check({name, " grids_sent"}, 64'(grids_sent), 64'(16'(exp_grids)));
    check({name, " cells_sent"}, 64'(cells_sent), 64'(exp_cells));
    if (exp_q.size() == 0) begin
      @(negedge clk);
      check({name, " empty_done pulse end"}, 64'(empty_done), 64'd0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    run_grid(v.name, v.grid, v.mask, 1'b0);
    check({v.name, " table beats"}, 64'(got_q.size()), 64'(v.exp_beats));
    if (v.exp_beats > 0 && got_q.size() > 0) begin
      check({v.name, " first beat"}, 64'({got_q[0].idx, got_q[0].val, got_q[0].first}),
            64'({7'(v.exp_fidx), 4'(v.exp_fval), 1'b1}));
      check({v.name, " last beat"}, 64'({got_q[$].idx, got_q[$].val, got_q[$].last}),
            64'({7'(v.exp_lidx), 4'(v.exp_lval), 1'b1}));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " ctl"}, 64'({load_ready, cell_valid, cell_first, cell_last, empty_done, bad_digit}),
          64'b100000);
    check({name, " idx/val"}, 64'({cell_index, cell_value}), 64'd0);
    check({name, " counters"}, 64'({grids_sent, cells_sent}), 64'd0);
  endtask

  initial begin
    zero_grid = '0;
    full_grid = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) full_grid[4*(r*9+c) +: 4] = 4'(c + 1);
    sparse_grid = '0;
    sparse_grid[4*5 +: 4]  = 4'd7;
    sparse_grid[4*40 +: 4] = 4'd3;
    bad_grid = full_grid;
    bad_grid[4*10 +: 4] = 4'hC;
    all_ones = '1;

    vecs[0] = '{"full",    full_grid,   all_ones,                       81, 0,  1, 80, 9};
    vecs[1] = '{"sparse",  sparse_grid, all_ones,                        2, 5,  7, 40, 3};
    vecs[2] = '{"mask0",   full_grid,   81'd0,                           0, 0,  0, 0,  0};
    vecs[3] = '{"single",  full_grid,   81'd1 << 33,                     1, 33, 7, 33, 7};
    vecs[4] = '{"allzero", zero_grid,   all_ones,                        0, 0,  0, 0,  0};
    vecs[5] = '{"ends",    full_grid,   (81'd1 << 80) | 81'd1,           2, 0,  1, 80, 9};

    rst = 1'b0; load_valid = 1'b0; load_grid = '0; load_mask = '0; abort = 1'b0; cell_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    check("bad_digit clean", 64'(bad_digit), 64'd0);

    // Random backpressure must not change the beat sequence.
    run_grid("random ready", full_grid, all_ones, 1'b1);

    // Abort while the third beat is stalled.
    load_grid = full_grid; load_mask = all_ones; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; cell_ready = 1'b1;
    @(negedge clk);
    check("abort beat1 idx", 64'(cell_index), 64'd1);
    @(negedge clk);
    check("abort beat3 shown", 64'({cell_valid, cell_index}), 64'({1'b1, 7'd2}));
    cell_ready = 1'b0;
    @(negedge clk);
    check("abort beat3 stalled", 64'({cell_valid, cell_index}), 64'({1'b1, 7'd2}));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_cells += 2;
    check("abort idle", 64'({cell_valid, load_ready}), 64'b01);
    check("abort cells_sent", 64'(cells_sent), 64'(exp_cells));
    check("abort grids_sent", 64'(grids_sent), 64'(16'(exp_grids)));
    run_vec(vecs[5]);

    // Abort coinciding with the only (last) beat: beat counts, grid does not.
    load_grid = full_grid; load_mask = 81'd1 << 33; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    check("abort+hs flags", 64'({cell_valid, cell_first, cell_last}), 64'b111);
    abort = 1'b1; cell_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; cell_ready = 1'b0;
    exp_cells += 1;
    check("abort+hs valid", 64'(cell_valid), 64'd0);
    check("abort+hs cells_sent", 64'(cells_sent), 64'(exp_cells));
    check("abort+hs grids_sent", 64'(grids_sent), 64'(16'(exp_grids)));

    // Abort beats a simultaneous load in IDLE.
    load_grid = full_grid; load_mask = 81'd1 << 33; load_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; abort = 1'b0;
    check("abort vs load", 64'({cell_valid, empty_done, load_ready}), 64'b001);
    @(negedge clk);
    check("abort vs load grids", 64'(grids_sent), 64'(16'(exp_grids)));

    // Out-of-range digit is sent unchanged and flags sticky bad_digit.
    run_grid("bad digit", bad_grid, all_ones, 1'b0);
    if (got_q.size() > 10) check("bad digit beat10", 64'({got_q[10].idx, got_q[10].val}), 64'({7'd10, 4'hC}));
    else check("bad digit beat10 present", 64'(got_q.size()), 64'd81);
    check("bad_digit set", 64'(bad_digit), 64'd1);
    run_vec(vecs[1]);
    check("bad_digit sticky", 64'(bad_digit), 64'd1);

    // Reset in the middle of a grid discards everything at once.
    load_grid = full_grid; load_mask = all_ones; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; cell_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid reset");
    cell_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("held reset");
    rst = 1'b1;
    exp_grids = 0;
    exp_cells = 0;
    @(negedge clk);
    check("post reset idle", 64'({cell_valid, load_ready}), 64'b01);
    run_vec(vecs[3]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sudoku_grid_tx.md
SUDOKU_GRID_TX -- requirements
Module: sudoku_grid_tx

Interface
REQ-001 Parameter SKIP_EMPTY, default 1, meaning: 1 = cells with value 0 are never transmitted; 0 = value 0 cells are transmitted if their mask bit is set.
REQ-002 clk  input  1  single clock, all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 load_valid  input  1  grid offer from producer.
REQ-005 load_ready  output  1  block accepts a grid.
REQ-006 load_grid  input  324  81 cells x 4 bits; cell i = bits [4i+3:4i]; i = row*9+col.
REQ-007 load_mask  input  81  bit i = 1 marks cell i for transmission.
REQ-008 abort  input  1  synchronous discard of the grid in flight.
REQ-009 cell_valid  output  1  cell beat present.
REQ-010 cell_ready  input  1  consumer accepts beat.
REQ-011 cell_index  output  7  cell number, 0..80.
REQ-012 cell_value  output  4  cell digit.
REQ-013 cell_first  output  1  first beat of the current grid.
REQ-014 cell_last  output  1  final beat of the current grid.
REQ-015 empty_done  output  1  one-cycle pulse: accepted grid had no eligible cells.
REQ-016 bad_digit  output  1  sticky flag: a transmitted value was 10..15.
REQ-017 grids_sent  output  16  completed-grid count.
REQ-018 cells_sent  output  32  completed-beat count.

Function
REQ-019 States SHALL be IDLE and SEND; load_ready SHALL be 1 exactly in IDLE.
REQ-020 Load handshake SHALL occur when load_valid && load_ready; grid and eligible vector SHALL be captured into registers.
REQ-021 Eligible vector SHALL be e[i] = load_mask[i] && (SKIP_EMPTY==0 || cell i != 0).
REQ-022 On a load at cycle T with e != 0, state SHALL be SEND at T+1 with cell_valid=1 and cell_index = lowest set bit of e.
REQ-023 On a load at cycle T with e == 0, state SHALL remain IDLE, empty_done SHALL be 1 at T+1 only, and grids_sent SHALL increment.
REQ-024 In SEND, cell_index SHALL always be the lowest set bit of the remaining vector; cells SHALL go out in ascending index order.
REQ-025 While cell_valid=1 and cell_ready=0, cell_index, cell_value, cell_first and cell_last SHALL hold stable.
REQ-026 On beat handshake, the sent bit SHALL clear and cells_sent SHALL increment; with cell_ready held high, beats SHALL be back-to-back with no bubble.
REQ-027 cell_first SHALL be 1 only on the first beat after a load; cell_last SHALL be 1 iff exactly one remaining bit is set. Both SHALL be 1 on a single-cell grid.
REQ-028 On the last-beat handshake, grids_sent SHALL increment and state SHALL return to IDLE next cycle; cell_valid=0 and load_ready=1 in that cycle.
REQ-029 bad_digit SHALL set on any beat handshake with cell_value >= 10; the digit SHALL be transmitted unchanged.
REQ-030 abort=1 in SEND SHALL force IDLE next cycle and drop cell_valid, even with the beat stalled; a coincident handshake SHALL still count in cells_sent; grids_sent SHALL NOT increment.
REQ-031 abort in IDLE SHALL have no effect; abort SHALL take priority over load in the same cycle, so no grid is accepted.
REQ-032 Counters SHALL wrap modulo 2^16 / 2^32.
REQ-033 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from cell_ready or load_valid to any output.

Reset
REQ-034 While rst=0: state IDLE, load_ready=1, cell_valid=0, cell_index=0, cell_value=0, cell_first=0, cell_last=0, empty_done=0, bad_digit=0, grids_sent=0, cells_sent=0, remaining vector=0.
REQ-035 Reset asserted mid-grid SHALL discard the grid immediately; no beat or count SHALL survive.

Verification
REQ-036 Mask=all ones, grid digits 1..9 per row, ready=1 constantly -> 81 beats on consecutive cycles; index 0..80; first on index 0, last on index 80; grids_sent=1, cells_sent=81.
REQ-037 SKIP_EMPTY=1, mask all ones, only cells 5 and 40 nonzero (7, 3) -> two beats, (5,7 first) then (40,3 last); cells_sent=2.
REQ-038 Mask=0 -> empty_done pulse at T+1, no cell_valid, grids_sent=1, load_ready stays 1.
REQ-039 ready toggled pseudo-randomly -> beats stable while stalled; sequence identical to the ready=1 run.
REQ-040 abort on the 3rd stalled beat -> cell_valid=0 next cycle, cells_sent=2, grids_sent unchanged; the next grid starts with cell_first=1.
REQ-041 Cell 10 = 4'hC, mask bit set -> beat carries value C and bit 10; bad_digit=1 until rst=0.
